// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores against a word memory.
// Ports: req_* (CPU request), resp_* (CPU response), mem_* (data memory).
// Build option: LSU_MISALIGN_TRAP_EN makes misaligned accesses fault.
module load_store_unit #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sgn_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;

  logic [31:0] widx;
  logic        misal;
  logic        bad;

  assign widx = {2'b00, req_addr[31:2]};

  always_comb begin
    misal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = (req_size == 2'b01 && req_addr[0])
         || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`endif
    bad = (req_size == 2'b11)
       || (widx >= 32'(MEM_DEPTH))
       || misal;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  // Halfword lane uses addr[1] only, so addr[0] is ignored.
  logic [31:0] bshift;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_data;
  logic [31:0] lmask;
  logic [31:0] lnew;
  logic [31:0] merged;

  always_comb begin
    bshift = mem_rdata >> {addr_q[1:0], 3'b000};
    lb     = bshift[7:0];
    lh     = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      2'b00:   ld_data = sgn_q ? {{24{lb[7]}}, lb}
                               : {24'h0, lb};
      2'b01:   ld_data = sgn_q ? {{16{lh[15]}}, lh}
                               : {16'h0, lh};
      default: ld_data = mem_rdata;
    endcase
    if (size_q == 2'b00) begin
      lmask = 32'h0000_00ff << {addr_q[1:0], 3'b000};
      lnew  = {24'h0, wd_q[7:0]} << {addr_q[1:0], 3'b000};
    end else begin
      lmask = 32'h0000_ffff << {addr_q[1], 4'b0000};
      lnew  = {16'h0, wd_q[15:0]} << {addr_q[1], 4'b0000};
    end
    merged = (mem_rdata & ~lmask) | lnew;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad)
            state_d = RESP;
          else if (req_we && req_size == 2'b10)
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        mem_addr = {2'b00, addr_q[31:2]};
        state_d  = we_q ? WR : RESP;
      end
      WR: begin
        mem_addr  = {2'b00, addr_q[31:2]};
        mem_wen   = 1'b1;
        mem_wdata = wd_q;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      addr_q     <= 32'h0;
      wd_q       <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            size_q     <= req_size;
            sgn_q      <= req_signed;
            addr_q     <= req_addr;
            wd_q       <= req_wdata;
            resp_rdata <= 32'h0;
            resp_err   <= bad;
          end
        end
        RD: begin
          // Sub-word store: old word with the new lane becomes write data.
          if (we_q)
            wd_q <= merged;
          else
            resp_rdata <= ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: table of directed accesses plus a
// reset-during-write sequence, against a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];
  int          tests = 0;
  int          fails = 0;
  int          wen_cnt = 0;

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

  load_store_unit #(.MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wen;
    int          chk_idx;
    logic [31:0] chk_val;
  } vec_t;

  vec_t v [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory writes happen at the edge where mem_wen was high.
  task automatic tick();
    if (mem_wen === 1'b1) begin
      wen_cnt++;
      if (mem_addr < 32'd256) mem[mem_addr[7:0]] = mem_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input string nm, input logic we, input logic [1:0] sz,
    input logic sg, input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] er, input logic ee, input int el,
    input int ew, input int ci, input logic [31:0] cv);
    vec_t t;
    t.name = nm; t.we = we; t.size = sz; t.sgn = sg;
    t.addr = a; t.wdata = wd; t.exp_rdata = er; t.exp_err = ee;
    t.exp_lat = el; t.exp_wen = ew; t.chk_idx = ci; t.chk_val = cv;
    return t;
  endfunction

  task automatic run_vec(input vec_t t);
    int lat;
    int w0;
    w0 = wen_cnt;
    chk({t.name, " ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_we     = t.we;
    req_size   = t.size;
    req_signed = t.sgn;
    req_addr   = t.addr;
    req_wdata  = t.wdata;
    tick();
    // Garbage on the request bus while busy must be ignored.
    req_we    = $urandom_range(0, 1) == 1;
    req_size  = 2'($urandom_range(0, 3));
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    req_valid = 1'b0;
    chk({t.name, " lat"}, lat, t.exp_lat);
    chk({t.name, " rdata"}, resp_rdata, t.exp_rdata);
    chk({t.name, " err"}, {31'h0, resp_err}, {31'h0, t.exp_err});
    resp_ready = 1'b0;
    tick();
    chk({t.name, " hold"},
        {resp_valid, resp_err, resp_rdata[29:0]},
        {1'b1, t.exp_err, t.exp_rdata[29:0]});
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({t.name, " wen"}, wen_cnt - w0, t.exp_wen);
    chk({t.name, " idle"}, {30'h0, resp_valid, req_ready}, 32'h1);
    chk({t.name, " mem"}, mem[t.chk_idx], t.chk_val);
  endtask

  initial begin
    int n;
    foreach (mem[i]) mem[i] = 32'h0;
    mem[8] = 32'h0000_0007;
    mem[3] = 32'h1122_3344;
    mem[4] = 32'h5566_7788;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;

    v[0]  = mk("lw_20", 0, 2'b10, 0, 32'h20, 0,
               32'h7, 0, 2, 0, 8, 32'h7);
    v[1]  = mk("sb_0d", 1, 2'b00, 0, 32'h0D, 32'hAB,
               0, 0, 3, 1, 3, 32'h1122_AB44);
    v[2]  = mk("sw_0c", 1, 2'b10, 0, 32'h0C, 32'h8000_00F0,
               0, 0, 2, 1, 3, 32'h8000_00F0);
    v[3]  = mk("lb_0c", 0, 2'b00, 1, 32'h0C, 0,
               32'hFFFF_FFF0, 0, 2, 0, 3, 32'h8000_00F0);
    v[4]  = mk("lhu_0e", 0, 2'b01, 0, 32'h0E, 0,
               32'h0000_8000, 0, 2, 0, 3, 32'h8000_00F0);
    v[5]  = mk("lh_0e", 0, 2'b01, 1, 32'h0E, 0,
               32'hFFFF_8000, 0, 2, 0, 3, 32'h8000_00F0);
    v[6]  = mk("lbu_0f", 0, 2'b00, 0, 32'h0F, 0,
               32'h80, 0, 2, 0, 3, 32'h8000_00F0);
    v[7]  = mk("lbu_0c", 0, 2'b00, 0, 32'h0C, 0,
               32'hF0, 0, 2, 0, 3, 32'h8000_00F0);
    v[8]  = mk("lw_400", 0, 2'b10, 0, 32'h400, 0,
               0, 1, 1, 0, 3, 32'h8000_00F0);
    v[9]  = mk("ld_sz3", 0, 2'b11, 0, 32'h20, 0,
               0, 1, 1, 0, 8, 32'h7);
`ifdef LSU_MISALIGN_TRAP_EN
    v[10] = mk("sw_22", 1, 2'b10, 0, 32'h22, 32'hDEAD_BEEF,
               0, 1, 1, 0, 8, 32'h7);
`else
    v[10] = mk("sw_22", 1, 2'b10, 0, 32'h22, 32'hDEAD_BEEF,
               0, 0, 2, 1, 8, 32'hDEAD_BEEF);
`endif
    v[11] = mk("sh_12", 1, 2'b01, 0, 32'h12, 32'h1234_CAFE,
               0, 0, 3, 1, 4, 32'hCAFE_7788);
`ifdef LSU_MISALIGN_TRAP_EN
    v[12] = mk("lh_13", 0, 2'b01, 1, 32'h13, 0,
               0, 1, 1, 0, 4, 32'hCAFE_7788);
`else
    v[12] = mk("lh_13", 0, 2'b01, 1, 32'h13, 0,
               32'hFFFF_CAFE, 0, 2, 0, 4, 32'hCAFE_7788);
`endif
    v[13] = mk("st_sz3", 1, 2'b11, 0, 32'h10, 32'h0,
               0, 1, 1, 0, 4, 32'hCAFE_7788);
    v[14] = mk("sw_3fc", 1, 2'b10, 0, 32'h3FC, 32'h1357_9BDF,
               0, 0, 2, 1, 255, 32'h1357_9BDF);

    tick();
    tick();
    chk("rst ready", {31'h0, req_ready}, 32'h1);
    chk("rst resp", {30'h0, resp_valid, resp_err}, 32'h0);
    chk("rst rdata", resp_rdata, 32'h0);
    chk("rst wen", {31'h0, mem_wen}, 32'h0);
    chk("rst maddr", mem_addr, 32'h0);
    chk("rst mwdata", mem_wdata, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 15; i++) run_vec(v[i]);

    // Reset while the write of a sub-word store is in progress.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h99;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rstwr in_wr", {31'h0, mem_wen}, 32'h1);
    rst = 1'b1;
    tick();
    chk("rstwr wen", {31'h0, mem_wen}, 32'h0);
    chk("rstwr ready", {31'h0, req_ready}, 32'h1);
    chk("rstwr maddr", mem_addr, 32'h0);
    rst = 1'b0;
    resp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid !== 1'b0) n++;
      tick();
    end
    resp_ready = 1'b0;
    chk("rstwr noresp", n, 0);
    run_vec(mk("lw_3fc", 0, 2'b10, 0, 32'h3FC, 0,
               32'h1357_9BDF, 0, 2, 0, 255, 32'h1357_9BDF));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
